// File: rtl/det_event_logger.sv
// det_event_logger: counts and timestamps detector pulses into a show-ahead FIFO read via valid/ready.
// Optional detection blanking after each accepted event is enabled by defining DET_LOG_HOLDOFF_EN.
module det_event_logger #(
  parameter int TS_W    = 16,
  parameter int CNT_W   = 16,
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     det_in,
  input  logic                     clr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         evt_cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            holdActive;
  logic            accept;
  logic            full;
  logic            pop;
  logic            push;

`ifdef DET_LOG_HOLDOFF_EN
  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  logic [HW-1:0] hcnt;

  // Loaded on every accepted event, so blanking covers the next HOLDOFF cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt <= '0;
    end else if (clr) begin
      hcnt <= '0;
    end else if (accept) begin
      hcnt <= HW'(HOLDOFF);
    end else if (hcnt != '0) begin
      hcnt <= hcnt - HW'(1);
    end
  end

  assign holdActive = (hcnt != '0);
`else
  // Constant false; HOLDOFF is referenced only so the parameter stays in use.
  assign holdActive = (HOLDOFF < 0);
`endif

  assign accept   = det_in && !clr && !holdActive;
  assign rd_valid = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = rd_valid && rd_ready && !clr;
  assign push     = accept && (!full || pop);
  assign rd_data  = rd_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= ts;
    end
  end

  // Pointers wrap naturally; occupancy is kept in its own register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
    end else if (clr) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      if (evt_cnt != '1) begin
        evt_cnt <= evt_cnt + CNT_W'(1);
      end
      if (full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: directed scenarios plus randomized traffic vs a queue model.
// Honours DET_LOG_HOLDOFF_EN the same way the design does.
module tb_det_event_logger;

  localparam int TS_W    = 16;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 3;
  localparam int LW      = $clog2(DEPTH) + 1;
`ifdef DET_LOG_HOLDOFF_EN
  localparam int GAP = HOLDOFF + 1;
`else
  localparam int GAP = 2;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              det;
  logic              clr;
  logic              rdReady;
  logic              rdValid;
  logic [TS_W-1:0]   rdData;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  evtCnt;
  logic              ovf;
  logic              sRdValid;
  logic [TS_W-1:0]   sRdData;
  logic [LW-1:0]     sLevel;
  logic [3:0]        sEvtCnt;
  logic              sOvf;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [TS_W-1:0] mTs;
  int              mCnt;
  bit              mOvf;
  logic [TS_W-1:0] mQ[$];
  longint          mCycle;
  longint          mLastAcc;
  bit              mHaveAcc;

  det_event_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rstn(rstn), .det_in(det), .clr(clr),
    .rd_valid(rdValid), .rd_ready(rdReady), .rd_data(rdData),
    .level(level), .evt_cnt(evtCnt), .ovf(ovf)
  );

  det_event_logger #(.TS_W(TS_W), .CNT_W(4), .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dutSmall (
    .clk(clk), .rstn(rstn), .det_in(det), .clr(clr),
    .rd_valid(sRdValid), .rd_ready(rdReady), .rd_data(sRdData),
    .level(sLevel), .evt_cnt(sEvtCnt), .ovf(sOvf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: a timestamp queue, a counter and an accept rule based on cycle distance.
  always @(posedge clk or negedge rstn) begin
    bit popNow;
    bit acc;
    if (!rstn) begin
      mTs = '0; mCnt = 0; mOvf = 0; mQ.delete(); mHaveAcc = 0; mCycle = 0; mLastAcc = 0;
    end else begin
      popNow = (mQ.size() > 0) && rdReady;
      if (clr) begin
        mQ.delete(); mTs = '0; mCnt = 0; mOvf = 0; mHaveAcc = 0;
      end else begin
        acc = det;
`ifdef DET_LOG_HOLDOFF_EN
        if (mHaveAcc && (mCycle - mLastAcc) <= HOLDOFF) acc = 0;
`endif
        if (popNow) void'(mQ.pop_front());
        if (acc) begin
          mCnt++;
          mHaveAcc = 1;
          mLastAcc = mCycle;
          if (mQ.size() < DEPTH) mQ.push_back(mTs);
          else mOvf = 1;
        end
        mTs = mTs + 16'd1;
      end
      mCycle++;
    end
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic doClear();
    clr = 1'b1; det = 1'b0; rdReady = 1'b0;
    nextCycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; det = 1'b0; clr = 1'b0; rdReady = 1'b0;
    repeat (2) nextCycle();
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %0d expected 0", rdValid); end
    checks++; if (rdData !== '0) begin failures++; $display("[TB] FAIL reset_rd_data: got %0d expected 0", rdData); end
    checks++; if (level !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (evtCnt !== '0) begin failures++; $display("[TB] FAIL reset_evt_cnt: got %0d expected 0", evtCnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %0d expected 0", ovf); end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    repeat (5) nextCycle();
    det = 1'b1;
    nextCycle();
    det = 1'b0;
    checks++; if (rdValid !== 1'b1) begin failures++; $display("[TB] FAIL single_rd_valid: got %0d expected 1", rdValid); end
    checks++; if (rdData !== 16'd5) begin failures++; $display("[TB] FAIL single_rd_data: got %0d expected 5", rdData); end
    checks++; if (level !== 4'd1) begin failures++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    checks++; if (evtCnt !== 16'd1) begin failures++; $display("[TB] FAIL single_evt_cnt: got %0d expected 1", evtCnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL single_ovf: got %0d expected 0", ovf); end
    rdReady = 1'b1;
    nextCycle();
    rdReady = 1'b0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL single_pop_valid: got %0d expected 0", rdValid); end
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level); end
  endtask

  task automatic test_overflow();
    doClear();
    for (int t = 0; t <= 2 + GAP * 9; t++) begin
      det = (t >= 2) && ((t - 2) % GAP == 0);
      nextCycle();
    end
    det = 1'b0;
    checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL ovf_level: got %0d expected 8", level); end
    checks++; if (evtCnt !== 16'd10) begin failures++; $display("[TB] FAIL ovf_evt_cnt: got %0d expected 10", evtCnt); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %0d expected 1", ovf); end
    rdReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdValid !== 1'b1 || rdData !== 16'(2 + GAP * i)) begin
        failures++; $display("[TB] FAIL ovf_drain[%0d]: got valid=%0d data=%0d expected valid=1 data=%0d", i, rdValid, rdData, 2 + GAP * i);
      end
      nextCycle();
    end
    rdReady = 1'b0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drained_valid: got %0d expected 0", rdValid); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %0d expected 1", ovf); end
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] exp[$];
    int t;
    doClear();
    t = 0;
    for (int i = 0; i <= GAP * 7; i++) begin
      det = (t % GAP == 0);
      if (det) exp.push_back(16'(t));
      nextCycle(); t++;
    end
    det = 1'b0;
    repeat (GAP) begin nextCycle(); t++; end
    checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL b2b_prefill_level: got %0d expected 8", level); end
    det = 1'b1; rdReady = 1'b1;
    void'(exp.pop_front());
    exp.push_back(16'(t));
    nextCycle(); t++;
    det = 1'b0; rdReady = 1'b0;
    checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL b2b_level: got %0d expected 8", level); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ovf: got %0d expected 0", ovf); end
    rdReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rdValid !== 1'b1 || rdData !== exp[i]) begin
        failures++; $display("[TB] FAIL b2b_drain[%0d]: got valid=%0d data=%0d expected valid=1 data=%0d", i, rdValid, rdData, exp[i]);
      end
      nextCycle();
    end
    rdReady = 1'b0;
  endtask

  task automatic test_clear();
    doClear();
    for (int t = 0; t <= GAP * 4; t++) begin
      det = (t % GAP == 0);
      nextCycle();
    end
    det = 1'b0;
    checks++; if (level !== 4'd5) begin failures++; $display("[TB] FAIL clr_prefill_level: got %0d expected 5", level); end
    clr = 1'b1; det = 1'b1; rdReady = 1'b1;
    nextCycle();
    clr = 1'b0; rdReady = 1'b0;
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL clr_level: got %0d expected 0", level); end
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL clr_rd_valid: got %0d expected 0", rdValid); end
    checks++; if (evtCnt !== 16'd0) begin failures++; $display("[TB] FAIL clr_evt_cnt: got %0d expected 0", evtCnt); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("[TB] FAIL clr_ovf: got %0d expected 0", ovf); end
    nextCycle();
    det = 1'b0;
    checks++; if (rdData !== 16'd0 || level !== 4'd1) begin failures++; $display("[TB] FAIL clr_ts_restart: got data=%0d level=%0d expected data=0 level=1", rdData, level); end
  endtask

  task automatic test_holdoff();
    int exp[$];
    doClear();
    repeat (10) nextCycle();
    det = 1'b1;
    repeat (5) nextCycle();
    det = 1'b0;
`ifdef DET_LOG_HOLDOFF_EN
    exp = '{10, 14};
`else
    exp = '{10, 11, 12, 13, 14};
`endif
    checks++; if (evtCnt !== 16'(exp.size())) begin failures++; $display("[TB] FAIL holdoff_evt_cnt: got %0d expected %0d", evtCnt, exp.size()); end
    rdReady = 1'b1;
    foreach (exp[i]) begin
      checks++;
      if (rdValid !== 1'b1 || rdData !== 16'(exp[i])) begin
        failures++; $display("[TB] FAIL holdoff_ts[%0d]: got valid=%0d data=%0d expected valid=1 data=%0d", i, rdValid, rdData, exp[i]);
      end
      nextCycle();
    end
    rdReady = 1'b0;
    checks++; if (rdValid !== 1'b0) begin failures++; $display("[TB] FAIL holdoff_drained: got %0d expected 0", rdValid); end
  endtask

  task automatic test_saturation();
    doClear();
    rdReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      det = 1'b1; nextCycle();
      det = 1'b0; repeat (GAP - 1) nextCycle();
    end
    checks++; if (sEvtCnt !== 4'd15) begin failures++; $display("[TB] FAIL sat_small_evt_cnt: got %0d expected 15", sEvtCnt); end
    checks++; if (evtCnt !== 16'd20) begin failures++; $display("[TB] FAIL sat_wide_evt_cnt: got %0d expected 20", evtCnt); end
    rdReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      det = 1'b1; nextCycle();
      det = 1'b0; repeat (GAP - 1) nextCycle();
    end
    det = 1'b1;
    #2 rstn = 1'b0;
    #1;
    checks++; if (rdValid !== 1'b0 || rdData !== '0 || level !== '0) begin failures++; $display("[TB] FAIL async_reset_fifo: got valid=%0d data=%0d level=%0d expected 0", rdValid, rdData, level); end
    checks++; if (evtCnt !== '0 || ovf !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_cnt: got evt=%0d ovf=%0d expected 0", evtCnt, ovf); end
    checks++; if (sEvtCnt !== '0 || sLevel !== '0 || sRdValid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_small: got evt=%0d level=%0d expected 0", sEvtCnt, sLevel); end
    det = 1'b0;
    nextCycle();
    rstn = 1'b1;
  endtask

  task automatic test_random();
    int expCnt;
    for (int c = 0; c < 800; c++) begin
      expCnt = (mCnt > 65535) ? 65535 : mCnt;
      checks++; if (rdValid !== (mQ.size() > 0)) begin failures++; $display("[TB] FAIL rand_rd_valid@%0d: got %0d expected %0d", c, rdValid, mQ.size() > 0); end
      checks++; if (level !== LW'(mQ.size())) begin failures++; $display("[TB] FAIL rand_level@%0d: got %0d expected %0d", c, level, mQ.size()); end
      checks++; if (evtCnt !== 16'(expCnt)) begin failures++; $display("[TB] FAIL rand_evt_cnt@%0d: got %0d expected %0d", c, evtCnt, expCnt); end
      checks++; if (sEvtCnt !== 4'((mCnt > 15) ? 15 : mCnt)) begin failures++; $display("[TB] FAIL rand_small_evt_cnt@%0d: got %0d expected %0d", c, sEvtCnt, (mCnt > 15) ? 15 : mCnt); end
      checks++; if (ovf !== mOvf) begin failures++; $display("[TB] FAIL rand_ovf@%0d: got %0d expected %0d", c, ovf, mOvf); end
      if (mQ.size() > 0) begin
        checks++; if (rdData !== mQ[0]) begin failures++; $display("[TB] FAIL rand_rd_data@%0d: got %0d expected %0d", c, rdData, mQ[0]); end
      end
      det = 1'($urandom_range(0, 1));
      if ((c / 100) % 2 == 1) rdReady = ($urandom_range(0, 7) == 0);
      else rdReady = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 79) == 0);
      nextCycle();
    end
    det = 1'b0; clr = 1'b0; rdReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_holdoff();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
